reg_read_stage: RTL and testbench
=================================

// Module: reg_read_stage
// PURPOSE
//  Parametrised register-read pipeline stage for the IITB RISC core, between decode and execute.
//  - Holds the architectural register file.
//  - Reads NUM_RD source operands per instruction.
//  - Resolves RAW hazards: EX forwarding, WB write-through, load-use stall.
//  - Presents operands to execute through a valid/ready output register.
// PARAMETERS
//  DATA_W   16  register / operand width
//  NUM_REGS 8   number of architectural registers (power of 2)
//  NUM_RD   2   number of source read ports
//  CTRL_W   19  width of decoded control bundle passed through unchanged
//  PC_REG   7   index of register aliased to PC; reads return in_pc
// PORTS
//  clk          in  1                  clock, rising edge
//  resetn       in  1                  asynchronous active-low reset
//  flush        in  1                  squash stage contents (branch mispredict)
//  in_valid     in  1                  decode presents an instruction
//  in_ready     out 1                  stage accepts instruction this cycle
//  in_pc        in  DATA_W             PC of incoming instruction
//  in_ctrl      in  CTRL_W             decoded control bundle
//  in_rs_addr   in  NUM_RD*IDX_W       source indices, port k at [k*IDX_W +: IDX_W]; IDX_W=$clog2(NUM_REGS)
//  in_rs_en     in  NUM_RD             port k source is used (hazard checks only if set)
//  out_valid    out 1                  operands valid to execute
//  out_ready    in  1                  execute accepts
//  out_pc       out DATA_W             registered in_pc
//  out_ctrl     out CTRL_W             registered in_ctrl
//  out_opnd     out NUM_RD*DATA_W      resolved operands, same packing as in_rs_addr
//  wb_en        in  1                  write-back enable
//  wb_addr      in  IDX_W              write-back register
//  wb_data      in  DATA_W             write-back data
//  ex_fwd_en    in  1                  EX result valid for forwarding
//  ex_fwd_addr  in  IDX_W              EX destination
//  ex_fwd_data  in  DATA_W             EX result
//  ex_is_load   in  1                  EX instruction is a load (data not yet available)
// BEHAVIOUR
//  Reset (resetn=0, async):
//    - all R[i]=0; out_valid=0; out_pc=0; out_ctrl=0; out_opnd=0.
//  Operand priority per port k, combinational:
//    1. rs==PC_REG -> in_pc
//    2. ex_fwd_en && ex_fwd_addr==rs && !ex_is_load -> ex_fwd_data
//    3. wb_en && wb_addr==rs -> wb_data (same-cycle write-through)
//    4. else R[rs]
//  Hazard:
//    - hazard = in_valid && any k with in_rs_en[k], rs!=PC_REG, ex_fwd_en, ex_is_load, ex_fwd_addr==rs.
//  Handshake:
//    - in_ready = (!out_valid || out_ready) && !hazard && !flush.
//    - Transfer when in_valid&&in_ready: operands/pc/ctrl registered, out_valid=1; latency 1 cycle.
//    - out_ready=1, out_valid=1, no transfer: out_valid<=0 (bubble), including during a hazard.
//    - out_valid=1, out_ready=0: all outputs hold stable.
//  Flush:
//    - out_valid<=0 next edge; incoming instruction dropped; out_opnd/out_pc/out_ctrl may hold stale data.
//  Write-back:
//    - wb_en writes R[wb_addr] at clk edge regardless of stall/flush.
//    - wb_addr==PC_REG is written, but reads still return in_pc.
//  Simultaneous ex and wb to same rs:
//    - EX wins (younger); a load in EX stalls even if WB matches.
// STRUCTURE
//  risc_pkg:
//    - DATA_W, NUM_REGS, IDX_W, PC_REG defaults.
//    - ctrl bundle typedef.
//    - idx_t typedef.
//  Sub-module regfile_bank:
//    - NUM_REGS x DATA_W, NUM_RD async read ports, 1 sync write port.
//    - Async reset to 0; write-through bypass.
//  Top: forward mux per port (generate loop), hazard detect, output register.
// TESTING
//  1. Reset then wb R3=0x00AA; next cycle read rs0=3 -> out_opnd[0]=0x00AA, out_valid=1 after 1 cycle.
//  2. Same cycle: wb R2=0x1234 and read rs1=2 -> out_opnd[1]=0x1234 (write-through).
//  3. EX fwd R5=0xBEEF (non-load), WB R5=0x1111, read rs0=5 -> 0xBEEF.
//  4. ex_is_load, ex_fwd_addr=4, read rs1=4 with in_rs_en[1]=1:
//     - in_ready=0 and out_valid bubble for that cycle.
//     - Drop ex_is_load -> accepted.
//  5. Hold out_ready=0 for 3 cycles with out_valid=1:
//     - outputs stable, in_ready=0.
//     - Then flush=1 -> out_valid=0 next edge.
//  6. Read rs0=7, in_pc=0x0040 -> out_opnd[0]=0x0040 even with wb R7=0xFFFF.
//     Assert resetn low mid-transfer -> out_valid=0 immediately.

Source files
------------

// File: rtl/risc_pkg.sv
// Shared sizing defaults and types for the IITB RISC register-read stage.
package risc_pkg;
    localparam int DEF_DATA_W   = 16;
    localparam int DEF_NUM_REGS = 8;
    localparam int DEF_NUM_RD   = 2;
    localparam int DEF_CTRL_W   = 19;
    localparam int DEF_PC_REG   = 7;
    localparam int DEF_IDX_W    = $clog2(DEF_NUM_REGS);

    typedef logic [DEF_CTRL_W-1:0] ctrl_t;
    typedef logic [DEF_IDX_W-1:0]  idx_t;
endpackage

// File: rtl/regfile_bank.sv
// Architectural register file: NUM_RD async read ports, one sync write port
// with same-cycle write-through so a reader sees data being written back.
module regfile_bank #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8,
    parameter int NUM_RD   = 2,
    localparam int IDX_W   = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     we,
    input  logic [IDX_W-1:0]         waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [NUM_RD*IDX_W-1:0]  raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata
);
    logic [NUM_REGS-1:0][DATA_W-1:0] mem_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)  mem_q        <= '0;
        else if (we)  mem_q[waddr] <= wdata;
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [IDX_W-1:0] ra;
        assign ra = raddr[k*IDX_W +: IDX_W];
        assign rdata[k*DATA_W +: DATA_W] = (we && waddr == ra) ? wdata : mem_q[ra];
    end
endmodule

// File: rtl/reg_read_stage.sv
// Register-read stage: operand forwarding, load-use stall and a valid/ready
// output register feeding execute.
module reg_read_stage
    import risc_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int NUM_RD   = DEF_NUM_RD,
    parameter int CTRL_W   = DEF_CTRL_W,
    parameter int PC_REG   = DEF_PC_REG,
    localparam int IDX_W   = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_pc,
    input  logic [CTRL_W-1:0]        in_ctrl,
    input  logic [NUM_RD*IDX_W-1:0]  in_rs_addr,
    input  logic [NUM_RD-1:0]        in_rs_en,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_pc,
    output logic [CTRL_W-1:0]        out_ctrl,
    output logic [NUM_RD*DATA_W-1:0] out_opnd,
    input  logic                     wb_en,
    input  logic [IDX_W-1:0]         wb_addr,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic                     ex_fwd_en,
    input  logic [IDX_W-1:0]         ex_fwd_addr,
    input  logic [DATA_W-1:0]        ex_fwd_data,
    input  logic                     ex_is_load
);
    localparam logic [IDX_W-1:0] PC_IDX = IDX_W'(PC_REG);

    logic [NUM_RD*DATA_W-1:0] rf_rdata;
    logic [NUM_RD*DATA_W-1:0] opnd_d;
    logic [NUM_RD-1:0]        haz_port;
    logic                     hazard;
    logic                     xfer;

    logic                     out_valid_q;
    logic [DATA_W-1:0]        out_pc_q;
    logic [CTRL_W-1:0]        out_ctrl_q;
    logic [NUM_RD*DATA_W-1:0] out_opnd_q;

    regfile_bank #(
        .DATA_W  (DATA_W),
        .NUM_REGS(NUM_REGS),
        .NUM_RD  (NUM_RD)
    ) u_rf (
        .clk   (clk),
        .resetn(resetn),
        .we    (wb_en),
        .waddr (wb_addr),
        .wdata (wb_data),
        .raddr (in_rs_addr),
        .rdata (rf_rdata)
    );

    // WB write-through lives in the regfile, so only PC alias and EX sit above it here.
    for (genvar k = 0; k < NUM_RD; k++) begin : g_port
        logic [IDX_W-1:0] rs;
        logic             ex_hit;
        assign rs     = in_rs_addr[k*IDX_W +: IDX_W];
        assign ex_hit = ex_fwd_en && (ex_fwd_addr == rs);
        assign opnd_d[k*DATA_W +: DATA_W] =
            (rs == PC_IDX)          ? in_pc       :
            (ex_hit && !ex_is_load) ? ex_fwd_data :
                                      rf_rdata[k*DATA_W +: DATA_W];
        assign haz_port[k] = in_rs_en[k] && (rs != PC_IDX) && ex_hit && ex_is_load;
    end

    assign hazard   = in_valid && (|haz_port);
    assign in_ready = (!out_valid_q || out_ready) && !hazard && !flush;
    assign xfer     = in_valid && in_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid_q <= 1'b0;
            out_pc_q    <= '0;
            out_ctrl_q  <= '0;
            out_opnd_q  <= '0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (xfer) begin
            out_valid_q <= 1'b1;
            out_pc_q    <= in_pc;
            out_ctrl_q  <= in_ctrl;
            out_opnd_q  <= opnd_d;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_pc    = out_pc_q;
    assign out_ctrl  = out_ctrl_q;
    assign out_opnd  = out_opnd_q;
endmodule

// File: tb/tb_reg_read_stage.sv
// Scoreboard bench for reg_read_stage: directed scenarios then random traffic
// against a register-array reference model.
module tb_reg_read_stage;
    typedef struct {
        logic [15:0] pc;
        logic [18:0] ctrl;
        logic [31:0] opnd;
    } item_t;

    logic        clk = 1'b0;
    logic        resetn, flush, in_valid, in_ready, out_valid, out_ready;
    logic [15:0] in_pc, out_pc, wb_data, ex_fwd_data;
    logic [18:0] in_ctrl, out_ctrl;
    logic [5:0]  in_rs_addr;
    logic [1:0]  in_rs_en;
    logic [31:0] out_opnd;
    logic        wb_en, ex_fwd_en, ex_is_load;
    logic [2:0]  wb_addr, ex_fwd_addr;

    int    n_chk = 0;
    int    n_pass = 0;
    bit    mon_en = 0;
    item_t q[$];
    logic [15:0] R [8];

    reg_read_stage dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_ctrl(in_ctrl),
        .in_rs_addr(in_rs_addr), .in_rs_en(in_rs_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_ctrl(out_ctrl), .out_opnd(out_opnd),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .ex_fwd_en(ex_fwd_en), .ex_fwd_addr(ex_fwd_addr), .ex_fwd_data(ex_fwd_data),
        .ex_is_load(ex_is_load)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Reference: what a source index reads given this cycle's inputs.
    function automatic logic [15:0] ref_read(input logic [2:0] rs);
        if (rs == 3'd7)                                       return in_pc;
        if (ex_fwd_en && ex_fwd_addr == rs && !ex_is_load)    return ex_fwd_data;
        if (wb_en && wb_addr == rs)                           return wb_data;
        return R[rs];
    endfunction

    function automatic bit ref_stall();
        bit s = 0;
        for (int k = 0; k < 2; k++) begin
            logic [2:0] rs = in_rs_addr[k*3 +: 3];
            if (in_rs_en[k] && rs != 3'd7 && ex_fwd_en && ex_is_load && ex_fwd_addr == rs) s = 1;
        end
        return in_valid && s;
    endfunction

    // Monitor: whatever execute sees must match the head of the scoreboard.
    always @(negedge clk) begin
        if (resetn && mon_en) begin
            chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
            if (out_valid && q.size() != 0) begin
                chk("out_pc",   64'(out_pc),   64'(q[0].pc));
                chk("out_ctrl", 64'(out_ctrl), 64'(q[0].ctrl));
                chk("out_opnd", 64'(out_opnd), 64'(q[0].opnd));
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    // One clock of stimulus: inputs already driven; model the handshake and WB.
    task automatic step();
        item_t it;
        bit    rdy;
        @(negedge clk); #1;
        rdy = (q.size() == 0 || out_ready) && !ref_stall() && !flush;
        chk("in_ready", 64'(in_ready), 64'(rdy));
        if (flush) q.delete();
        else if (in_valid && rdy) begin
            it.pc   = in_pc;
            it.ctrl = in_ctrl;
            for (int k = 0; k < 2; k++) it.opnd[k*16 +: 16] = ref_read(in_rs_addr[k*3 +: 3]);
            q.push_back(it);
        end
        @(posedge clk);
        if (wb_en) R[wb_addr] = wb_data;
        #1;
    endtask

    task automatic idle();
        flush = 0; in_valid = 0; in_rs_en = 2'b00; in_rs_addr = '0;
        in_pc = '0; in_ctrl = '0; out_ready = 1;
        wb_en = 0; wb_addr = '0; wb_data = '0;
        ex_fwd_en = 0; ex_fwd_addr = '0; ex_fwd_data = '0; ex_is_load = 0;
    endtask

    task automatic issue(input logic [2:0] rs0, input logic [2:0] rs1, input logic [1:0] en,
                         input logic [15:0] pc);
        in_valid = 1; in_rs_addr = {rs1, rs0}; in_rs_en = en; in_pc = pc;
        in_ctrl = 19'($urandom);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        idle();
        resetn = 0;
        for (int i = 0; i < 8; i++) R[i] = '0;
        #12;
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst out_pc",    64'(out_pc),    64'd0);
        chk("rst out_ctrl",  64'(out_ctrl),  64'd0);
        chk("rst out_opnd",  64'(out_opnd),  64'd0);
        @(posedge clk); #1; resetn = 1; mon_en = 1;

        // 1: write-back then read on the following cycle
        wb_en = 1; wb_addr = 3; wb_data = 16'h00AA; step();
        idle(); issue(3'd3, 3'd0, 2'b01, 16'h0010); step();
        chk("t1 opnd0", 64'(out_opnd[15:0]), 64'h00AA);
        chk("t1 valid", 64'(out_valid), 64'd1);

        // 2: same-cycle write-through
        idle(); issue(3'd0, 3'd2, 2'b10, 16'h0012);
        wb_en = 1; wb_addr = 2; wb_data = 16'h1234; step();
        chk("t2 opnd1", 64'(out_opnd[31:16]), 64'h1234);

        // 3: EX beats WB on the same register
        idle(); issue(3'd5, 3'd0, 2'b01, 16'h0014);
        ex_fwd_en = 1; ex_fwd_addr = 5; ex_fwd_data = 16'hBEEF;
        wb_en = 1; wb_addr = 5; wb_data = 16'h1111; step();
        chk("t3 opnd0", 64'(out_opnd[15:0]), 64'hBEEF);

        // 4: load-use stall, then release
        idle(); issue(3'd0, 3'd4, 2'b10, 16'h0016);
        ex_fwd_en = 1; ex_fwd_addr = 4; ex_is_load = 1; ex_fwd_data = 16'h7777;
        #1 chk("t4 stall ready", 64'(in_ready), 64'd0);
        step();
        chk("t4 bubble", 64'(out_valid), 64'd0);
        ex_is_load = 0; step();
        chk("t4 accepted", 64'(out_valid), 64'd1);
        chk("t4 opnd1", 64'(out_opnd[31:16]), 64'h7777);

        // 5: back-pressure for three cycles, then flush
        idle(); issue(3'd1, 3'd2, 2'b11, 16'h0018); step();
        out_ready = 0; issue(3'd3, 3'd3, 2'b11, 16'h001A);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t5 hold pc", 64'(out_pc), 64'h0018);
        end
        flush = 1; step();
        chk("t5 flushed", 64'(out_valid), 64'd0);

        // 6: PC alias wins over write-back, then async reset mid-transfer
        idle(); issue(3'd7, 3'd1, 2'b11, 16'h0040);
        wb_en = 1; wb_addr = 7; wb_data = 16'hFFFF; step();
        chk("t6 opnd0", 64'(out_opnd[15:0]), 64'h0040);
        idle();
        #2 resetn = 0;
        #1 chk("t6 async valid", 64'(out_valid), 64'd0);
        chk("t6 async pc", 64'(out_pc), 64'd0);
        q.delete();
        for (int i = 0; i < 8; i++) R[i] = '0;
        @(posedge clk); #1; resetn = 1;

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            in_valid    = ($urandom_range(3) != 0);
            in_rs_addr  = 6'($urandom);
            in_rs_en    = 2'($urandom);
            in_pc       = 16'($urandom);
            in_ctrl     = 19'($urandom);
            out_ready   = ($urandom_range(3) != 0);
            flush       = ($urandom_range(15) == 0);
            wb_en       = ($urandom_range(1) != 0);
            wb_addr     = 3'($urandom);
            wb_data     = 16'($urandom);
            ex_fwd_en   = ($urandom_range(1) != 0);
            ex_fwd_addr = 3'($urandom);
            ex_fwd_data = 16'($urandom);
            ex_is_load  = ($urandom_range(2) == 0);
            step();
        end
        idle(); step(); step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
